// File: rtl/fir_tx_sequencer_if.sv
// rtl/fir_tx_sequencer_if.sv - control/status bundle between the host and the FIR tx sequencer
interface fir_tx_sequencer_if #(
  parameter int NB_DIV = 8
);
  logic              i_start;
  logic              i_stop;
  logic [NB_DIV-1:0] i_div;
  logic              o_enable;
  logic              o_valid;
  logic              o_prbs;
  logic              o_busy;
  logic [1:0]        o_state;
  logic [15:0]       o_sym_count;

  modport master (
    output i_start, i_stop, i_div,
    input  o_enable, o_valid, o_prbs, o_busy, o_state, o_sym_count
  );

  modport slave (
    input  i_start, i_stop, i_div,
    output o_enable, o_valid, o_prbs, o_busy, o_state, o_sym_count
  );
endinterface

// File: rtl/fir_tx_sequencer.sv
// rtl/fir_tx_sequencer.sv - sample tick, symbol strobe and PRBS9 source with flush/drain framing
module fir_tx_sequencer #(
  parameter int         OVER_SAMP = 8,
  parameter int         NB_COUNT  = 3,
  parameter int         N_BAUDS   = 7,
  parameter int         NB_DIV    = 8,
  parameter logic [8:0] PRBS_SEED = 9'h1FF
) (
  input  logic                clk,
  input  logic                i_rst,
  fir_tx_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam int                    NB_LEFT    = $clog2(N_BAUDS + 1);
  localparam logic [NB_LEFT-1:0]    LEFT_LAST  = NB_LEFT'(N_BAUDS - 1);
  localparam logic [NB_COUNT-1:0]   PHASE_LAST = NB_COUNT'(OVER_SAMP - 1);

  state_t              r_state;
  logic [NB_DIV-1:0]   r_div_reg;
  logic [NB_DIV-1:0]   r_div_cnt;
  logic [NB_COUNT-1:0] r_phase;
  logic [8:0]          r_lfsr;
  logic                r_stop_pend;
  logic [NB_LEFT-1:0]  r_sym_left;
  logic [15:0]         r_sym_count;
  logic                r_enable;
  logic                r_valid;
  logic                r_prbs;

  state_t w_next_state;
  logic   w_start_ok;
  logic   w_to_drain;
  logic   w_tick;
  logic   w_en;
  logic   w_sym;

  // Ticks are dropped on the edge that returns to IDLE so no enable leaks into IDLE.
  assign w_tick = (r_state != ST_IDLE) && (r_div_cnt == r_div_reg);
  assign w_en   = w_tick && (w_next_state != ST_IDLE);
  assign w_sym  = w_en && (r_phase == PHASE_LAST);

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Flush/drain accounting acts on the cycle the strobe is visible, one clk after it is issued.
  always_comb begin
    w_next_state = r_state;
    w_start_ok   = 1'b0;
    w_to_drain   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.i_start) begin
          w_next_state = ST_FLUSH;
          w_start_ok   = 1'b1;
        end
      end
      ST_FLUSH: begin
        if (r_valid && (r_sym_left == LEFT_LAST)) begin
          if (r_stop_pend) begin
            w_next_state = ST_DRAIN;
            w_to_drain   = 1'b1;
          end else begin
            w_next_state = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (r_valid && r_stop_pend) begin
          w_next_state = ST_DRAIN;
          w_to_drain   = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (r_valid && (r_sym_left == LEFT_LAST)) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_div_reg   <= '0;
      r_div_cnt   <= '0;
      r_phase     <= '0;
      r_lfsr      <= PRBS_SEED;
      r_stop_pend <= 1'b0;
      r_sym_left  <= '0;
      r_sym_count <= '0;
      r_enable    <= 1'b0;
      r_valid     <= 1'b0;
      r_prbs      <= 1'b0;
    end else begin
      r_enable <= w_en;
      r_valid  <= w_sym;
      r_prbs   <= w_sym && (r_state == ST_RUN) && r_lfsr[8];

      // Phase is never cleared on start so it stays lock-stepped with the FIR.
      if (w_en) begin
        r_phase <= (r_phase == PHASE_LAST) ? '0 : r_phase + 1'b1;
      end

      if (w_start_ok) begin
        r_div_reg <= bus.i_div;
        r_div_cnt <= '0;
      end else if (r_state != ST_IDLE) begin
        r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
      end

      if (w_start_ok) begin
        r_lfsr      <= PRBS_SEED;
        r_sym_count <= '0;
      end else if (w_sym && (r_state == ST_RUN)) begin
        r_lfsr <= {r_lfsr[7:0], r_lfsr[8] ^ r_lfsr[4]};
        if (r_sym_count != 16'hFFFF) begin
          r_sym_count <= r_sym_count + 16'd1;
        end
      end

      if (w_start_ok || w_to_drain) begin
        r_sym_left <= '0;
      end else if (r_valid && ((r_state == ST_FLUSH) || (r_state == ST_DRAIN))) begin
        r_sym_left <= r_sym_left + 1'b1;
      end

      if ((r_state == ST_DRAIN) && (w_next_state == ST_IDLE)) begin
        r_stop_pend <= 1'b0;
      end else if (bus.i_stop && ((r_state == ST_FLUSH) || (r_state == ST_RUN))) begin
        r_stop_pend <= 1'b1;
      end
    end
  end

  assign bus.o_enable    = r_enable;
  assign bus.o_valid     = r_valid;
  assign bus.o_prbs      = r_prbs;
  assign bus.o_busy      = (r_state != ST_IDLE);
  assign bus.o_state     = r_state;
  assign bus.o_sym_count = r_sym_count;

endmodule

// File: tb/tb_fir_tx_sequencer.sv
// tb/tb_fir_tx_sequencer.sv - directed self-checking bench for fir_tx_sequencer
module tb_fir_tx_sequencer;

  localparam int NSYM = 531;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic exp_bits [0:NSYM-1];
  logic got_bits [0:NSYM-1];

  fir_tx_sequencer_if #(.NB_DIV(8)) bus ();

  fir_tx_sequencer #(
    .OVER_SAMP(8),
    .NB_COUNT (3),
    .N_BAUDS  (7),
    .NB_DIV   (8),
    .PRBS_SEED(9'h1FF)
  ) dut (
    .clk  (clk),
    .i_rst(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rst         = 1'b1;
    bus.i_start = 1'b0;
    bus.i_stop  = 1'b0;
    bus.i_div   = 8'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_start(input logic [7:0] div);
    bus.i_div   = div;
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.i_stop = 1'b1;
    @(negedge clk);
    bus.i_stop = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.o_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.o_enable, bus.o_valid, bus.o_prbs, bus.o_busy} !== 4'b0 ||
          bus.o_state !== 2'd0 || bus.o_sym_count !== 16'd0) begin
        n_fail++;
        $display("FAIL reset_idle cycle %0d: en=%b val=%b prbs=%b busy=%b state=%0d cnt=%0d, expected all 0",
                 i, bus.o_enable, bus.o_valid, bus.o_prbs, bus.o_busy, bus.o_state, bus.o_sym_count);
      end
    end
  endtask

  task automatic test_flush_timing();
    int n;
    bit ok;
    do_reset();
    pulse_start(8'd3);
    bus.i_div = 8'd9;
    n_checks++;
    if (bus.o_busy !== 1'b1 || bus.o_state !== 2'd1) begin
      n_fail++;
      $display("FAIL start_to_flush: busy=%b state=%0d, expected busy=1 state=1", bus.o_busy, bus.o_state);
    end
    for (int k = 0; k < 2; k++) begin
      n = 0;
      for (int i = 1; i <= 50; i++) begin
        @(negedge clk);
        if (bus.o_enable) begin
          n = i;
          break;
        end
      end
      n_checks++;
      if (n !== 4) begin
        n_fail++;
        $display("FAIL enable_spacing %0d: got %0d clks, expected 4", k, n);
      end
    end
    wait_valid(200, ok);
    n_checks++;
    if (!ok || bus.o_prbs !== 1'b0 || bus.o_state !== 2'd1) begin
      n_fail++;
      $display("FAIL flush_first: ok=%b prbs=%b state=%0d, expected 1 0 1", ok, bus.o_prbs, bus.o_state);
    end
    for (int k = 2; k <= 7; k++) begin
      n = 0;
      for (int i = 1; i <= 100; i++) begin
        @(negedge clk);
        if (bus.o_valid) begin
          n = i;
          break;
        end
      end
      n_checks++;
      if (n !== 32 || bus.o_prbs !== 1'b0 || bus.o_state !== 2'd1) begin
        n_fail++;
        $display("FAIL flush_valid %0d: period=%0d prbs=%b state=%0d, expected 32 0 1",
                 k, n, bus.o_prbs, bus.o_state);
      end
    end
    @(negedge clk);
    n_checks++;
    if (bus.o_state !== 2'd2) begin
      n_fail++;
      $display("FAIL flush_to_run: state=%0d, expected 2", bus.o_state);
    end
  endtask

  task automatic test_prbs();
    bit         ok;
    int         cnt_err;
    int         mdl_err;
    int         per_err;
    logic [8:0] head;
    logic [3:0] nxt;
    do_reset();
    pulse_start(8'd0);
    for (int k = 0; k < 7; k++) wait_valid(100, ok);
    cnt_err = 0;
    mdl_err = 0;
    for (int i = 0; i < NSYM; i++) begin
      wait_valid(100, ok);
      if (!ok) begin
        n_checks++;
        n_fail++;
        $display("FAIL prbs_timeout: symbol %0d not seen, expected a strobe", i);
        break;
      end
      got_bits[i] = bus.o_prbs;
      if (bus.o_prbs !== exp_bits[i]) mdl_err++;
      if (bus.o_sym_count !== 16'(i + 1)) cnt_err++;
      if (i == 100) pulse_start(8'd5);
    end
    for (int j = 0; j < 9; j++) head[8-j] = got_bits[j];
    for (int j = 0; j < 4; j++) nxt[3-j] = got_bits[9+j];
    n_checks++;
    if (head !== 9'h1FF) begin
      n_fail++;
      $display("FAIL prbs_first9: got %b, expected 111111111", head);
    end
    n_checks++;
    if (nxt !== 4'b0000) begin
      n_fail++;
      $display("FAIL prbs_next4: got %b, expected 0000", nxt);
    end
    n_checks++;
    if (mdl_err !== 0) begin
      n_fail++;
      $display("FAIL prbs_sequence: %0d bit errors, expected 0", mdl_err);
    end
    per_err = 0;
    for (int i = 0; i < NSYM - 511; i++) if (got_bits[i] !== got_bits[i+511]) per_err++;
    n_checks++;
    if (per_err !== 0) begin
      n_fail++;
      $display("FAIL prbs_period511: %0d differences, expected 0", per_err);
    end
    n_checks++;
    if (cnt_err !== 0 || bus.o_sym_count !== 16'd531 || bus.o_state !== 2'd2) begin
      n_fail++;
      $display("FAIL prbs_sym_count: errs=%0d final=%0d state=%0d, expected 0 531 2",
               cnt_err, bus.o_sym_count, bus.o_state);
    end
  endtask

  task automatic test_stop_run();
    bit ok;
    int stray;
    do_reset();
    pulse_start(8'd0);
    for (int k = 0; k < 17; k++) wait_valid(100, ok);
    pulse_stop();
    wait_valid(100, ok);
    n_checks++;
    if (!ok || bus.o_prbs !== exp_bits[10] || bus.o_sym_count !== 16'd11 || bus.o_state !== 2'd2) begin
      n_fail++;
      $display("FAIL stop_run_last: ok=%b prbs=%b cnt=%0d state=%0d, expected 1 %b 11 2",
               ok, bus.o_prbs, bus.o_sym_count, bus.o_state, exp_bits[10]);
    end
    for (int k = 1; k <= 7; k++) begin
      wait_valid(100, ok);
      n_checks++;
      if (!ok || bus.o_prbs !== 1'b0 || bus.o_state !== 2'd3 || bus.o_sym_count !== 16'd11) begin
        n_fail++;
        $display("FAIL stop_run_drain %0d: ok=%b prbs=%b state=%0d cnt=%0d, expected 1 0 3 11",
                 k, ok, bus.o_prbs, bus.o_state, bus.o_sym_count);
      end
    end
    @(negedge clk);
    n_checks++;
    if (bus.o_state !== 2'd0 || bus.o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_run_idle: state=%0d busy=%b, expected 0 0", bus.o_state, bus.o_busy);
    end
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.o_enable || bus.o_valid) stray++;
      @(negedge clk);
    end
    n_checks++;
    if (stray !== 0) begin
      n_fail++;
      $display("FAIL idle_quiet: %0d strobes seen, expected 0", stray);
    end
  endtask

  task automatic test_stop_flush();
    bit         ok;
    logic [1:0] exp_st;
    do_reset();
    pulse_start(8'd0);
    for (int k = 0; k < 2; k++) wait_valid(100, ok);
    pulse_stop();
    for (int k = 3; k <= 14; k++) begin
      exp_st = (k <= 7) ? 2'd1 : 2'd3;
      wait_valid(100, ok);
      n_checks++;
      if (!ok || bus.o_prbs !== 1'b0 || bus.o_state !== exp_st) begin
        n_fail++;
        $display("FAIL stop_flush_sym %0d: ok=%b prbs=%b state=%0d, expected 1 0 %0d",
                 k, ok, bus.o_prbs, bus.o_state, exp_st);
      end
    end
    @(negedge clk);
    n_checks++;
    if (bus.o_state !== 2'd0 || bus.o_busy !== 1'b0 || bus.o_sym_count !== 16'd0) begin
      n_fail++;
      $display("FAIL stop_flush_idle: state=%0d busy=%b cnt=%0d, expected 0 0 0",
               bus.o_state, bus.o_busy, bus.o_sym_count);
    end
  endtask

  task automatic test_start_stop_together();
    bit ok;
    do_reset();
    bus.i_div   = 8'd0;
    bus.i_start = 1'b1;
    bus.i_stop  = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    bus.i_stop  = 1'b0;
    n_checks++;
    if (bus.o_state !== 2'd1) begin
      n_fail++;
      $display("FAIL start_stop_accept: state=%0d, expected 1", bus.o_state);
    end
    for (int k = 0; k < 7; k++) wait_valid(100, ok);
    @(negedge clk);
    n_checks++;
    if (!ok || bus.o_state !== 2'd2) begin
      n_fail++;
      $display("FAIL start_stop_run: ok=%b state=%0d, expected 1 2", ok, bus.o_state);
    end
  endtask

  task automatic test_reset_mid_run();
    bit   ok;
    logic first [0:4];
    int   err;
    do_reset();
    pulse_start(8'd0);
    for (int k = 0; k < 7; k++) wait_valid(100, ok);
    for (int k = 0; k < 5; k++) begin
      wait_valid(100, ok);
      first[k] = bus.o_prbs;
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({bus.o_enable, bus.o_valid, bus.o_prbs, bus.o_busy} !== 4'b0 ||
        bus.o_state !== 2'd0 || bus.o_sym_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_mid_run: en=%b val=%b prbs=%b busy=%b state=%0d cnt=%0d, expected all 0",
               bus.o_enable, bus.o_valid, bus.o_prbs, bus.o_busy, bus.o_state, bus.o_sym_count);
    end
    pulse_start(8'd0);
    for (int k = 0; k < 7; k++) wait_valid(100, ok);
    err = 0;
    for (int k = 0; k < 5; k++) begin
      wait_valid(100, ok);
      if (!ok || bus.o_prbs !== first[k] || bus.o_prbs !== exp_bits[k]) err++;
    end
    n_checks++;
    if (err !== 0) begin
      n_fail++;
      $display("FAIL restart_reseed: %0d bit errors, expected 0", err);
    end
  endtask

  initial begin
    logic [8:0] l;
    l = 9'h1FF;
    for (int i = 0; i < NSYM; i++) begin
      exp_bits[i] = l[8];
      l = {l[7:0], l[8] ^ l[4]};
    end
    test_reset();
    test_flush_timing();
    test_prbs();
    test_stop_run();
    test_stop_flush();
    test_start_stop_together();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
